// File: rtl/vcb_mod_cntr.sv
// Parametrised up/down counter, modulus MAX+1, with parallel load, cascade outputs and sticky OVF.
// Define CNT_SAT_EN to make limit events saturate instead of wrap.
module vcb_mod_cntr #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ce,
    input  logic             up,
    input  logic             L,
    input  logic [WIDTH-1:0] di,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CEO,
    output logic             OVF
);

    logic [WIDTH-1:0] q_d;
    logic             ovf_d;
    logic [WIDTH-1:0] load_val;

    // TC marks the value at which the next enabled count is a limit event.
    assign TC       = up ? (Q == MAX) : (Q == '0);
    assign CEO      = ce & TC & ~L;
    assign load_val = (di > MAX) ? MAX : di;

    always_comb begin
        q_d   = Q;
        ovf_d = OVF;
        if (L) begin
            q_d   = load_val;
            ovf_d = 1'b0;
        end else if (ce) begin
            if (TC) begin
`ifdef CNT_SAT_EN
                q_d = Q;
`else
                q_d = up ? '0 : MAX;
`endif
                ovf_d = 1'b1;
            end else begin
                q_d = up ? Q + WIDTH'(1) : Q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            Q   <= '0;
            OVF <= 1'b0;
        end else begin
            Q   <= q_d;
            OVF <= ovf_d;
        end
    end

endmodule
